mixout_i2s_tx: RTL and testbench

MIXOUT_I2S_TX -- requirements
Module: mixout_i2s_tx

---
 rtl/mixout_i2s_tx_pkg.sv | 16 +
 rtl/mixout_i2s_tx.sv | 100 ++++++++++
 tb/tb_mixout_i2s_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mixout_i2s_tx_pkg.sv
// rtl/mixout_i2s_tx_pkg.sv - shared audio constants for the I2S output stage
package mixout_i2s_tx_pkg;

  localparam int SAMPLE_WIDTH = 24;
  localparam int FRAME_CLKS   = 1024;
  localparam int BCK_DIV      = 16;
  localparam int SLOT_BITS    = 32;
  localparam int FC_W         = $clog2(FRAME_CLKS);
  localparam int BCK_LOG2     = $clog2(BCK_DIV);

  // Word for channel ch starts one BCK after its LRCK edge (I2S delay bit).
  function automatic logic [FC_W-1:0] load_fc(input int ch);
    return FC_W'(BCK_DIV + ch * SLOT_BITS * BCK_DIV);
  endfunction

endpackage

// File: rtl/mixout_i2s_tx.sv
// rtl/mixout_i2s_tx.sv - pulls stereo samples from the mixer and serializes them as I2S
module mixout_i2s_tx
  import mixout_i2s_tx_pkg::*;
#(
  parameter int NUM_CH_OUT = 2,
  parameter int POP_LEAD   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [NUM_CH_OUT-1:0]   pop_o,
  input  logic [NUM_CH_OUT-1:0]   ack_i,
  input  logic [SAMPLE_WIDTH-1:0] data_i,
  output logic                    bck_o,
  output logic                    lrck_o,
  output logic                    sdata_o,
  output logic [NUM_CH_OUT-1:0]   underrun_o
);

  localparam logic [FC_W-1:0] POP_FC = FC_W'(FRAME_CLKS - POP_LEAD);

  logic [FC_W-1:0]         fc_q, fc_d;
  logic [NUM_CH_OUT-1:0]   pending_q, pending_d;
  logic [NUM_CH_OUT-1:0]   valid_q, valid_d;
  logic [SAMPLE_WIDTH-1:0] hold_q [NUM_CH_OUT];
  logic [SAMPLE_WIDTH-1:0] hold_d [NUM_CH_OUT];
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    sdata_q, sdata_d;
  logic [SAMPLE_WIDTH-1:0] load_word;
  logic                    any_load;
  logic                    pop_now;
  logic                    bit_edge;

  assign fc_d     = fc_q + 1'b1;
  assign pop_now  = (fc_q == POP_FC);
  assign bit_edge = (fc_q[BCK_LOG2-1:0] == '0);
  assign pop_o    = {NUM_CH_OUT{pop_now}};
  assign bck_o    = fc_q[BCK_LOG2-1];
  assign lrck_o   = fc_q[FC_W-1];

  // A load point wins over a same-cycle ack; a pop wins over a same-cycle clear.
  always_comb begin
    pending_d  = pending_q;
    valid_d    = valid_q;
    hold_d     = hold_q;
    load_word  = '0;
    any_load   = 1'b0;
    underrun_o = '0;
    for (int c = 0; c < NUM_CH_OUT; c++) begin
      if (fc_q == load_fc(c)) begin
        any_load = 1'b1;
        if (valid_q[c]) begin
          load_word = hold_q[c];
        end else begin
          underrun_o[c] = 1'b1;
        end
        valid_d[c]   = 1'b0;
        pending_d[c] = 1'b0;
      end else if (ack_i[c] && pending_q[c]) begin
        hold_d[c]  = data_i;
        valid_d[c] = 1'b1;
      end
      if (pop_now) begin
        pending_d[c] = 1'b1;
      end
    end
    if (any_load) begin
      sdata_d = load_word[SAMPLE_WIDTH-1];
      shift_d = load_word << 1;
    end else begin
      sdata_d = shift_q[SAMPLE_WIDTH-1];
      shift_d = shift_q << 1;
    end
  end

  // New bit appears in the falling-edge cycle itself, held until the next one.
  assign sdata_o = bit_edge ? sdata_d : sdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_q      <= '0;
      pending_q <= '0;
      valid_q   <= '0;
      shift_q   <= '0;
      sdata_q   <= 1'b0;
      for (int c = 0; c < NUM_CH_OUT; c++) begin
        hold_q[c] <= '0;
      end
    end else begin
      fc_q      <= fc_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      if (bit_edge) begin
        shift_q <= shift_d;
        sdata_q <= sdata_d;
      end
    end
  end

endmodule

// File: tb/tb_mixout_i2s_tx.sv
// tb/tb_mixout_i2s_tx.sv - self-checking bench for mixout_i2s_tx
module tb_mixout_i2s_tx;

  localparam int POP_LEAD   = 64;
  localparam int POP_FC     = 1024 - POP_LEAD;
  localparam int L_LOAD_OFF = POP_LEAD + 16;
  localparam int R_LOAD_OFF = POP_LEAD + 528;
  localparam int RUN_LEN    = POP_LEAD + 1024;

  logic        clk;
  logic        rst;
  logic [1:0]  pop_o;
  logic [1:0]  ack_i;
  logic [23:0] data_i;
  logic        bck_o;
  logic        lrck_o;
  logic        sdata_o;
  logic [1:0]  underrun_o;

  int errors = 0;
  int checks = 0;

  int          m_fc;
  logic [1:0]  m_pend;
  logic [1:0]  m_valid;
  logic [23:0] m_hold [2];
  logic [23:0] m_word [2];
  logic [30:0] cap [2];
  logic [1:0]  ur_seen;

  typedef struct {
    int          l_off;
    logic [23:0] l_data;
    int          r_off;
    logic [23:0] r_data;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    logic [1:0]  exp_ur;
  } vec_t;

  vec_t vecs [9];

  mixout_i2s_tx #(.NUM_CH_OUT(2), .POP_LEAD(POP_LEAD)) dut (
    .clk(clk), .rst(rst), .pop_o(pop_o), .ack_i(ack_i), .data_i(data_i),
    .bck_o(bck_o), .lrck_o(lrck_o), .sdata_o(sdata_o), .underrun_o(underrun_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int load_pt(input int c);
    return 16 + 512 * c;
  endfunction

  // Serial line as a function of frame position: bit k of a slot word sits in BCK k after its load.
  function automatic logic model_sdata();
    int rel;
    for (int c = 0; c < 2; c++) begin
      rel = m_fc - load_pt(c);
      if (rel >= 0 && rel < 24 * 16) return m_word[c][23 - rel / 16];
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_fc    = 0;
    m_pend  = '0;
    m_valid = '0;
    ur_seen = '0;
    for (int c = 0; c < 2; c++) begin
      m_hold[c] = '0;
      m_word[c] = '0;
      cap[c]    = '0;
    end
  endtask

  task automatic step(input logic [1:0] ack, input logic [23:0] data);
    logic [1:0] exp_ur;
    logic [1:0] exp_pop;
    logic       exp_sd;
    logic       exp_bck;
    logic       exp_lr;
    int         rel;
    ack_i  = ack;
    data_i = data;
    exp_ur = '0;
    for (int c = 0; c < 2; c++) begin
      if (m_fc == load_pt(c)) begin
        m_word[c]  = m_valid[c] ? m_hold[c] : 24'h0;
        exp_ur[c]  = ~m_valid[c];
        m_valid[c] = 1'b0;
        m_pend[c]  = 1'b0;
      end
    end
    exp_sd  = model_sdata();
    exp_pop = (m_fc == POP_FC) ? 2'b11 : 2'b00;
    exp_bck = ((m_fc / 8) % 2) == 1;
    exp_lr  = m_fc >= 512;
    #1;
    chk($sformatf("outputs fc=%0d {pop,ur,bck,lrck,sd}", m_fc),
        {25'h0, pop_o, underrun_o, bck_o, lrck_o, sdata_o},
        {25'h0, exp_pop, exp_ur, exp_bck, exp_lr, exp_sd});
    if (m_fc == 0) begin
      cap[0]  = '0;
      cap[1]  = '0;
      ur_seen = '0;
    end
    ur_seen |= underrun_o;
    for (int c = 0; c < 2; c++) begin
      rel = m_fc - load_pt(c);
      if (rel >= 0 && rel < 496 && rel % 16 == 8) cap[c] = {cap[c][29:0], sdata_o};
    end
    for (int c = 0; c < 2; c++) begin
      if (ack[c] && m_pend[c]) begin
        m_hold[c]  = data;
        m_valid[c] = 1'b1;
      end
    end
    if (m_fc == POP_FC) m_pend = 2'b11;
    m_fc = (m_fc + 1) % 1024;
    @(negedge clk);
  endtask

  task automatic wait_pop();
    while (m_fc != POP_FC) step(2'b00, 24'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0]  a;
    logic [23:0] d;
    wait_pop();
    for (int k = 0; k < RUN_LEN; k++) begin
      a = {k == v.r_off, k == v.l_off};
      d = (k == v.l_off) ? v.l_data : ((k == v.r_off) ? v.r_data : 24'h0);
      step(a, d);
    end
    chk({tag, " left word"},  {1'b0, cap[0]}, {1'b0, v.exp_l, 7'h0});
    chk({tag, " right word"}, {1'b0, cap[1]}, {1'b0, v.exp_r, 7'h0});
    chk({tag, " underrun"},   {30'h0, ur_seen}, {30'h0, v.exp_ur});
  endtask

  task automatic check_idle_frame(input string tag);
    for (int k = 0; k < 1024; k++) step(2'b00, 24'h0);
    chk({tag, " underrun"},   {30'h0, ur_seen}, 32'h3);
    chk({tag, " left word"},  {1'b0, cap[0]}, 32'h0);
    chk({tag, " right word"}, {1'b0, cap[1]}, 32'h0);
  endtask

  task automatic hold_reset(input int n, input string tag);
    ack_i = 2'b00;
    rst   = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("%s reset outputs cyc %0d", tag, k),
          {25'h0, pop_o, underrun_o, bck_o, lrck_o, sdata_o}, 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{-1, 24'h0, -1, 24'h0, 24'h0, 24'h0, 2'b11};
    vecs[1] = '{30, 24'h800001, 31, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 2'b00};
    vecs[2] = '{30, 24'hABCDEF, -1, 24'h0, 24'hABCDEF, 24'h0, 2'b10};
    vecs[3] = '{L_LOAD_OFF, 24'h123456, 40, 24'h654321, 24'h0, 24'h654321, 2'b01};
    vecs[4] = '{L_LOAD_OFF - 1, 24'h5A5A5A, R_LOAD_OFF - 1, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 2'b00};
    vecs[5] = '{10, 24'h00FF00, R_LOAD_OFF, 24'h777777, 24'h00FF00, 24'h0, 2'b10};
    vecs[6] = '{20, 24'h0F0F0F, 20, 24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F, 2'b00};
    vecs[7] = '{POP_LEAD + 100, 24'hFFFFFF, 50, 24'h111111, 24'h0, 24'h111111, 2'b01};
    vecs[8] = '{25, 24'h800000, 26, 24'h000001, 24'h800000, 24'h000001, 2'b00};

    rst    = 1'b1;
    ack_i  = 2'b00;
    data_i = 24'h0;
    model_reset();
    @(negedge clk);
    hold_reset(3, "initial");
    check_idle_frame("first frame");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.l_off  = $urandom_range(1, 100);
      rv.r_off  = $urandom_range(1, R_LOAD_OFF + 30);
      rv.l_data = 24'($urandom);
      rv.r_data = (rv.r_off == rv.l_off) ? rv.l_data : 24'($urandom);
      rv.exp_l  = (rv.l_off < L_LOAD_OFF) ? rv.l_data : 24'h0;
      rv.exp_r  = (rv.r_off < R_LOAD_OFF) ? rv.r_data : 24'h0;
      rv.exp_ur = {rv.r_off >= R_LOAD_OFF, rv.l_off >= L_LOAD_OFF};
      run_vec(rv, $sformatf("rand%0d", i));
    end

    wait_pop();
    for (int k = 0; k < POP_LEAD + 300; k++) step({1'b0, k == 30}, 24'hC3C3C3);
    hold_reset(4, "mid-word");
    check_idle_frame("post-reset frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
